// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter encodings and PC field helpers for the branch predictor
//
// Purpose: definitions common to the predictor top, its saturating counter and
// any block that needs to decode a BTB index/tag from a PC.
// Ports: none (package).
package bp_pkg;

    // Default geometry; the top re-declares the entry layout with its own
    // parameters, this struct documents and serves the default configuration.
    localparam int DEF_XLEN     = 32;
    localparam int DEF_ENTRIES  = 16;
    localparam int DEF_CTR_BITS = 2;

    typedef struct packed {
        logic                                        valid;
        logic [DEF_XLEN-$clog2(DEF_ENTRIES)-3:0]     tag;
        logic [DEF_XLEN-1:0]                         target;
        logic [DEF_CTR_BITS-1:0]                     ctr;
    } bp_entry_t;

    // Saturated-taken encoding: all ones.
    function automatic logic [31:0] ctr_max(input int bits);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < bits; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    // Weakly taken: MSB set, remaining bits clear.
    function automatic logic [31:0] ctr_weak_t(input int bits);
        logic [31:0] v;
        v = '0;
        v[bits-1] = 1'b1;
        return v;
    endfunction

    // Weakly not-taken: MSB clear, remaining bits set (0 for a 1-bit counter).
    function automatic logic [31:0] ctr_weak_nt(input int bits);
        return ctr_max(bits - 1);
    endfunction

    // pc[1:0] never participate; index sits directly above them.
    function automatic logic [31:0] bp_index(input logic [63:0] pc, input int idx_bits);
        return 32'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, resolver update and perf-counter bundle
//
// Purpose: groups the predictor's lookup, training and counter signals.
// Modports: master = pipeline side (drives lookup/update/invalidate),
//           slave  = predictor (drives pred_* and the counters).
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_is_jump;
    logic             upd_mispredict;
    logic             invalidate;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispredict, invalidate,
        input  pred_taken, pred_target, hit_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_jump, upd_mispredict, invalidate,
        output pred_taken, pred_target, hit_count, mispredict_count
    );
endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational next state of a saturating direction counter
//
// Purpose: computes the trained counter value for one BTB entry.
// Ports: ctr_i (current), inc_i / dec_i (saturating step), force_max_i
//        (jump: jump straight to all ones, wins over inc/dec), ctr_o (next).
module bp_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                force_max_i,
    output logic [CTR_BITS-1:0] ctr_o
);
    localparam logic [CTR_BITS-1:0] MAX = '1;

    always_comb begin
        ctr_o = ctr_i;
        if (force_max_i) begin
            ctr_o = MAX;
        end else if (inc_i) begin
            if (ctr_i != MAX) ctr_o = ctr_i + 1'b1;
        end else if (dec_i) begin
            if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
//
// Purpose: same-cycle taken/target prediction for fetch, trained by the
// resolver one update per cycle, with hit and mispredict perf counters.
// Ports: clk, reset (synchronous, active-high), bp (branch_predictor_if.slave:
//        lookup_pc -> pred_taken/pred_target, upd_* training, invalidate,
//        hit_count, mispredict_count). Interface XLEN/CNT_W must match ours.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_W    = XLEN - IDX_BITS - 2;

    localparam logic [CTR_BITS-1:0] C_MAX     = CTR_BITS'(ctr_max(CTR_BITS));
    localparam logic [CTR_BITS-1:0] C_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] C_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t           table_q [ENTRIES];
    entry_t           table_d [ENTRIES];
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    entry_t              lk_e, up_e;
    logic                lk_hit, up_hit;
    logic                pred_taken;
    logic [CTR_BITS-1:0] ctr_next;

    // Lookup and update decode both read table_q, so a same-cycle lookup of
    // an index being trained sees the pre-update entry.
    always_comb begin
        lk_idx = IDX_BITS'(bp_index(64'(bp.lookup_pc), IDX_BITS));
        lk_tag = TAG_W'(bp_tag(64'(bp.lookup_pc), IDX_BITS));
        lk_e   = table_q[lk_idx];
        lk_hit = lk_e.valid && (lk_e.tag == lk_tag);

        up_idx = IDX_BITS'(bp_index(64'(bp.upd_pc), IDX_BITS));
        up_tag = TAG_W'(bp_tag(64'(bp.upd_pc), IDX_BITS));
        up_e   = table_q[up_idx];
        up_hit = up_e.valid && (up_e.tag == up_tag);
    end

    // Prediction is masked during reset so fetch never follows a stale entry
    // in the cycle the reset is being sampled.
    always_comb begin
        pred_taken     = lk_hit && lk_e.ctr[CTR_BITS-1] && !reset;
        bp.pred_taken  = pred_taken;
        bp.pred_target = pred_taken ? lk_e.target : '0;
    end

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .ctr_i       (up_e.ctr),
        .inc_i       (bp.upd_taken),
        .dec_i       (!bp.upd_taken),
        .force_max_i (bp.upd_is_jump),
        .ctr_o       (ctr_next)
    );

    always_comb begin
        table_d = table_q;
        if (bp.invalidate) begin
            // Invalidate wins over a concurrent update; targets/ctrs are left stale.
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i].valid = 1'b0;
            end
        end else if (bp.upd_valid) begin
            if (up_hit) begin
                table_d[up_idx].ctr = ctr_next;
                if (bp.upd_taken || bp.upd_is_jump) begin
                    table_d[up_idx].target = bp.upd_target;
                end
            end else if (bp.upd_taken || bp.upd_is_jump) begin
                // Allocation overwrites whatever tag held this index.
                table_d[up_idx].valid  = 1'b1;
                table_d[up_idx].tag    = up_tag;
                table_d[up_idx].target = bp.upd_target;
                table_d[up_idx].ctr    = bp.upd_is_jump ? C_MAX : C_WEAK_T;
            end
        end

        hit_count_d        = hit_count_q + CNT_W'(lk_hit);
        mispredict_count_d = mispredict_count_q + CNT_W'(bp.upd_valid && bp.upd_mispredict);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= C_WEAK_NT;
            end
            hit_count_q        <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            hit_count_q        <= hit_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bp.hit_count        = hit_count_q;
    assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32), .CNT_W(32)) bp_if ();

    branch_predictor #(
        .XLEN     (32),
        .ENTRIES  (16),
        .CTR_BITS (2),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if)
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    // Monitor: samples away from the active edge whenever the driver flagged
    // this cycle as carrying an expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got=empty expected=entry");
            end else begin
                mon_e = sb.pop_front();
                cmp({mon_e.name, "_taken"},  32'(bp_if.pred_taken), 32'(mon_e.pt));
                cmp({mon_e.name, "_target"}, bp_if.pred_target, mon_e.tgt);
                cmp({mon_e.name, "_hits"},   bp_if.hit_count, mon_e.hc);
                cmp({mon_e.name, "_misp"},   bp_if.mispredict_count, mon_e.mc);
            end
        end
    end

    task automatic expect_out(input string n, input logic pt, input logic [31:0] tgt,
                              input logic [31:0] hc, input logic [31:0] mc);
        sb.push_back('{n, pt, tgt, hc, mc});
        chk_en = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic jump, input logic misp);
        bp_if.upd_valid      = 1'b1;
        bp_if.upd_pc         = pc;
        bp_if.upd_taken      = taken;
        bp_if.upd_target     = tgt;
        bp_if.upd_is_jump    = jump;
        bp_if.upd_mispredict = misp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_en               = 1'b0;
        reset                = 1'b0;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_is_jump    = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        bp_if.invalidate     = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        bp_if.lookup_pc      = 32'h100;
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_pc         = '0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_target     = '0;
        bp_if.upd_is_jump    = 1'b0;
        bp_if.upd_mispredict = 1'b0;
        bp_if.invalidate     = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // reset state
        bp_if.lookup_pc = 32'h100; expect_out("reset", 0, 0, 0, 0); tick();
        // allocate taken branch; same-cycle lookup still misses
        upd(32'h100, 1, 32'h80, 0, 0); expect_out("alloc_same", 0, 0, 0, 0); tick();
        expect_out("alloc_hit", 1, 32'h80, 0, 0); tick();
        // not-taken training 10->01->00->00->00
        upd(32'h100, 0, 32'h0, 0, 0); expect_out("nt1_old", 1, 32'h80, 1, 0); tick();
        upd(32'h100, 0, 32'h0, 0, 0); expect_out("nt1_new", 0, 0, 2, 0); tick();
        upd(32'h100, 0, 32'h0, 0, 0); expect_out("nt3", 0, 0, 3, 0); tick();
        upd(32'h100, 0, 32'h0, 0, 0); expect_out("nt4", 0, 0, 4, 0); tick();
        expect_out("nt_floor", 0, 0, 5, 0); tick();
        // two taken steps needed from 00 proves no underflow; target follows
        upd(32'h100, 1, 32'h80, 0, 0); expect_out("t_from0", 0, 0, 6, 0); tick();
        upd(32'h100, 1, 32'h90, 0, 0); expect_out("t_01", 0, 0, 7, 0); tick();
        expect_out("t_10", 1, 32'h90, 8, 0); tick();
        // saturate at 11, then one not-taken must leave it taken
        upd(32'h100, 1, 32'h90, 0, 0); expect_out("sat_a", 1, 32'h90, 9, 0); tick();
        upd(32'h100, 1, 32'h90, 0, 0); expect_out("sat_b", 1, 32'h90, 10, 0); tick();
        upd(32'h100, 0, 32'h0, 0, 0);  expect_out("sat_c", 1, 32'h90, 11, 0); tick();
        expect_out("sat_hold", 1, 32'h90, 12, 0); tick();
        // eviction: 0x140 shares index 0 with a different tag
        upd(32'h140, 1, 32'h300, 0, 0); expect_out("evict_pre", 1, 32'h90, 13, 0); tick();
        expect_out("evicted_old", 0, 0, 14, 0); tick();
        bp_if.lookup_pc = 32'h140; expect_out("evict_new", 1, 32'h300, 14, 0); tick();
        // jump allocates at all-ones: one not-taken still predicts taken
        bp_if.lookup_pc = 32'h184;
        upd(32'h184, 1, 32'h400, 1, 0); expect_out("jmp_alloc", 0, 0, 15, 0); tick();
        upd(32'h184, 0, 32'h0, 0, 0);   expect_out("jmp_hit", 1, 32'h400, 15, 0); tick();
        expect_out("jmp_max", 1, 32'h400, 16, 0); tick();
        // invalidate drops a simultaneous taken update; counters keep counting
        bp_if.lookup_pc  = 32'h140;
        bp_if.invalidate = 1'b1;
        upd(32'h200, 1, 32'h500, 0, 1); expect_out("inv_pre", 1, 32'h300, 17, 0); tick();
        bp_if.lookup_pc = 32'h200;
        upd(32'h10, 0, 32'h0, 0, 1); expect_out("inv_200", 0, 0, 18, 1); tick();
        bp_if.lookup_pc = 32'h140;
        bp_if.upd_mispredict = 1'b1; expect_out("inv_140", 0, 0, 18, 2); tick();
        bp_if.lookup_pc = 32'h184;
        upd(32'h10, 0, 32'h0, 0, 1); expect_out("inv_184", 0, 0, 18, 2); tick();
        bp_if.lookup_pc = 32'h100;
        upd(32'h100, 1, 32'h88, 0, 0); expect_out("misp3", 0, 0, 18, 3); tick();
        // reset mid-operation masks prediction and drops the pending update
        reset = 1'b1;
        upd(32'h140, 1, 32'h99, 0, 0); expect_out("rst_mask", 0, 0, 18, 3); tick();
        expect_out("rst_100", 0, 0, 0, 0); tick();
        bp_if.lookup_pc = 32'h140; expect_out("rst_140", 0, 0, 0, 0); tick();

        tick();
        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the hazard-handled RV32 pipeline. It holds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. Fetch gets a same-cycle taken/target prediction; the Control_Hazard_Unit resolution path trains the tables and increments performance counters. It replaces static predict-not-taken so that the fetch PC mux can redirect before decode.

## Interface
Parameters:
- XLEN, 32, address/target width
- ENTRIES, 16, BTB depth; power of two, ≥ 2
- CTR_BITS, 2, direction counter width, ≥ 1
- CNT_W, 32, performance counter width

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- lookup_pc  in  XLEN  fetch-stage PC
- pred_taken  out  1  predict redirect this cycle
- pred_target  out  XLEN  predicted next PC; 0 when pred_taken=0
- upd_valid  in  1  resolved control-flow instruction this cycle
- upd_pc  in  XLEN  PC of resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target
- upd_is_jump  in  1  unconditional (JAL/JALR)
- upd_mispredict  in  1  resolver detected a misprediction
- invalidate  in  1  clear all entries (e.g. after self-modifying store)
- hit_count  out  CNT_W  lookups that hit a valid entry
- mispredict_count  out  CNT_W  updates with upd_mispredict=1

## Operation
- IDX_BITS = log2(ENTRIES). Index = pc[IDX_BITS+1:2]. Tag = pc[XLEN-1:IDX_BITS+2]. pc[1:0] are ignored.
- An entry holds valid, tag, target, and a counter ctr[CTR_BITS-1:0].
- Hit: entry valid and tag equal.
- pred_taken = hit && ctr MSB. pred_target = entry target when pred_taken, else 0.
- Update with upd_valid=1, entry at upd_pc:
  - Hit, upd_is_jump: ctr ← all-ones; target ← upd_target.
  - Hit, branch taken: ctr saturating +1; target ← upd_target.
  - Hit, branch not taken: ctr saturating −1; target unchanged.
  - Miss, taken or jump: allocate (overwrite) the entry. valid←1, tag, target ← upd_target. ctr ← all-ones for a jump, else weakly-taken (MSB=1, other bits 0).
  - Miss, not taken: no allocation, no table change.
- hit_count increments by 1 each cycle a lookup hits. It is gated only by reset.
- mispredict_count increments when upd_valid && upd_mispredict.
- Both counters wrap modulo 2^CNT_W.
- invalidate=1: all valid bits cleared at the next edge. Targets and ctr are retained but unused.

## Timing
- Lookup is combinational: pred_* are valid in the same cycle as lookup_pc.
- Updates commit at the rising clk edge. A lookup of the same index in the update cycle sees the pre-update value; the new value is visible the following cycle.
- Latency from update to visible prediction: 1 cycle.
- Reset:
  - All valid bits ← 0.
  - All ctr ← weakly-not-taken (MSB=0, other bits 1; for CTR_BITS=1, 0).
  - Both counters ← 0.
  - pred_taken=0 and pred_target=0 from the first cycle reset is sampled high.
- Reset has priority over invalidate, and invalidate has priority over upd_valid in the same cycle (the update is dropped). Counters still count during invalidate.
- Reset asserted mid-operation discards the update pending that cycle.
- Allocation into an index that holds another tag silently evicts the old entry.
- Saturation: ctr never wraps at 0 or at all-ones.

## Structure
- Shared package bp_pkg:
  - bp_entry_t struct (valid, tag, target, ctr)
  - Counter encodings CTR_MAX, CTR_WEAK_T, CTR_WEAK_NT as functions of CTR_BITS
  - Index/tag extraction functions
- One sub-module, bp_sat_counter (CTR_BITS): combinational next-state for inc/dec/force-max. It is instantiated once on the update path.
- Table is a flop array; no SRAM macro.

## Test plan
- Reset, then lookup_pc=0x100 → pred_taken=0, pred_target=0, hit_count=0.
- Taken branch at pc 0x100, target 0x80 (miss, allocate). Next cycle lookup 0x100 → pred_taken=1, target 0x80, hit_count=1.
- Four not-taken updates at 0x100 (CTR_BITS=2): ctr 10→01→00→00. pred_taken=0 after the first update; no underflow.
- Update and lookup of 0x100 in the same cycle → old prediction. Next cycle → new prediction.
- ENTRIES=16: allocate 0x100, then taken branch at 0x140 (same index, different tag). Lookup 0x100 → miss; lookup 0x140 → hit.
- invalidate with simultaneous taken update at 0x200 → next cycle all lookups miss and 0x200 is not allocated. Three upd_mispredict pulses → mispredict_count=3.
